warp_fetch_pc: RTL and testbench

- Per-warp instruction-fetch PC unit in the IF stage.
- It is the receiving end of the SIMT divergence-stack interface: it consumes Stall_SIMT_IF, UpdatePC_Qual1_SIMT_IF, UpdatePC_Qual2_SIMT_IF and TA_Warp_SIMT_IF, plus branch and jump targets.
- It owns the warp PC, issues fetches to the I-cache (1-cycle latency), and delivers instructions to the instruction buffer (IB) through a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 39 +++
 rtl/warp_fetch_pc_if.sv | 41 ++++
 rtl/fetch_out_slot.sv | 59 +++++
 rtl/warp_fetch_pc.sv | 176 +++++++++++++++++
 tb/tb_warp_fetch_pc.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the per-warp instruction-fetch PC unit.
//   - fetch_state_e  : warp fetch FSM states (IDLE, RUN, DRAIN)
//   - redirect_src_e : which redirect source wins this cycle
//   - PC_W_DEF / INSTR_W_DEF : default PC and instruction widths
//   - PC_STEP        : byte distance between sequential instructions
//   - redirect_select: priority encoder Qual2 > Qual1 > Jump
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    QUAL2 = 2'd1,
    QUAL1 = 2'd2,
    JUMP  = 2'd3
  } redirect_src_e;

  // Reconvergence/RET beats a divergent-branch redirect, which beats a jump.
  function automatic redirect_src_e redirect_select(input logic qual2,
                                                    input logic qual1,
                                                    input logic jump);
    if (qual2)      return QUAL2;
    else if (qual1) return QUAL1;
    else if (jump)  return JUMP;
    else            return NONE;
  endfunction

endpackage

// File: rtl/warp_fetch_pc_if.sv
// ----------------------------------------------------------------------------
// warp_fetch_pc_if
// Bundles the I-cache request/response pair and the instruction-buffer
// valid/ready handshake seen by the fetch PC unit.
//   master : the fetch unit (drives Req/Addr and the IB slot outputs)
//   slave  : the I-cache + IB side (drives Hit/Instr and Ready)
// Signals:
//   Req_IF_ICache, Addr_IF_ICache      fetch request / address
//   Hit_ICache_IF, Instr_ICache_IF     response, one cycle after Req
//   Valid_IF_IB, Ready_IB_IF           output slot handshake
//   Instr_IF_IB, PCplus4_IF_IB         delivered instruction and its PC+4
// ----------------------------------------------------------------------------
interface warp_fetch_pc_if #(
  parameter int PC_W    = fetch_pkg::PC_W_DEF,
  parameter int INSTR_W = fetch_pkg::INSTR_W_DEF
);

  logic               Req_IF_ICache;
  logic [PC_W-1:0]    Addr_IF_ICache;
  logic               Hit_ICache_IF;
  logic [INSTR_W-1:0] Instr_ICache_IF;
  logic               Valid_IF_IB;
  logic               Ready_IB_IF;
  logic [INSTR_W-1:0] Instr_IF_IB;
  logic [PC_W-1:0]    PCplus4_IF_IB;

  modport master (
    output Req_IF_ICache, Addr_IF_ICache,
    input  Hit_ICache_IF, Instr_ICache_IF,
    output Valid_IF_IB, Instr_IF_IB, PCplus4_IF_IB,
    input  Ready_IB_IF
  );

  modport slave (
    input  Req_IF_ICache, Addr_IF_ICache,
    output Hit_ICache_IF, Instr_ICache_IF,
    input  Valid_IF_IB, Instr_IF_IB, PCplus4_IF_IB,
    output Ready_IB_IF
  );

endinterface

// File: rtl/fetch_out_slot.sv
// ----------------------------------------------------------------------------
// fetch_out_slot
// One-entry valid/ready holding register between the I-cache response and
// the instruction buffer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            a response is written this cycle
//   load_instr      instruction to store
//   load_pcplus4    PC+4 of that instruction
//   flush           drop the held entry (redirect)
//   ready           IB accepts the held entry this cycle
//   valid, instr, pcplus4  slot contents
//   can_accept      slot is empty or is being drained this cycle
// ----------------------------------------------------------------------------
module fetch_out_slot #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pcplus4,
  input  logic               flush,
  input  logic               ready,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pcplus4,
  output logic               can_accept
);

  logic               valid_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pcplus4_reg;

  assign can_accept = !valid_reg || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      instr_reg   <= '0;
      pcplus4_reg <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      // Covers both the empty case and a same-cycle pop-and-refill.
      valid_reg   <= 1'b1;
      instr_reg   <= load_instr;
      pcplus4_reg <= load_pcplus4;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid   = valid_reg;
  assign instr   = instr_reg;
  assign pcplus4 = pcplus4_reg;

endmodule

// File: rtl/warp_fetch_pc.sv
// ----------------------------------------------------------------------------
// warp_fetch_pc
// Per-warp IF-stage PC unit: owns the warp PC, issues fetches to a 1-cycle
// I-cache, applies SIMT/jump redirects and hands instructions to the IB.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   Start_TM_IF, StartPC_TM_IF    launch the warp at a PC (IDLE only)
//   Exit_ID_IF                    EXIT decoded, drain and go idle
//   Stall_SIMT_IF                 hold issue while a branch resolves
//   UpdatePC_Qual1_SIMT_IF + BrTarget_EX_IF   divergent-branch redirect
//   UpdatePC_Qual2_SIMT_IF + TA_Warp_SIMT_IF  reconvergence/RET redirect
//   Jump_ID_IF + JumpTarget_ID_IF             unconditional jump
//   bus (warp_fetch_pc_if.master) I-cache request/response and IB handshake
//   Active_IF_TM                  warp is in RUN or DRAIN
// Optional: define FETCH_PERF_CNT_EN to add 16-bit saturating counters
//   StallCycles_IF, MissCycles_IF, Redirects_IF (cleared by rst and Start).
// ----------------------------------------------------------------------------
module warp_fetch_pc
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start_TM_IF,
  input  logic [PC_W-1:0] StartPC_TM_IF,
  input  logic            Exit_ID_IF,
  input  logic            Stall_SIMT_IF,
  input  logic            UpdatePC_Qual1_SIMT_IF,
  input  logic [PC_W-1:0] BrTarget_EX_IF,
  input  logic            UpdatePC_Qual2_SIMT_IF,
  input  logic [PC_W-1:0] TA_Warp_SIMT_IF,
  input  logic            Jump_ID_IF,
  input  logic [PC_W-1:0] JumpTarget_ID_IF,
  warp_fetch_pc_if.master bus,
  output logic            Active_IF_TM
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     StallCycles_IF,
  output logic [15:0]     MissCycles_IF,
  output logic [15:0]     Redirects_IF
`endif
);

  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  fetch_state_e    state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] req_pc_reg;
  logic            inflight_reg;

  redirect_src_e   redirect_src;
  logic [PC_W-1:0] raw_target;
  logic [PC_W-1:0] redirect_target;
  logic            run_now;
  logic            redirect_taken;
  logic            resp_reject;
  logic            req;
  logic            slot_load;
  logic            slot_valid;
  logic            slot_can_accept;

  assign run_now      = (state_reg == RUN);
  assign redirect_src = redirect_select(UpdatePC_Qual2_SIMT_IF,
                                        UpdatePC_Qual1_SIMT_IF, Jump_ID_IF);
  // Exit outranks any redirect: the target is simply dropped.
  assign redirect_taken = run_now && !Exit_ID_IF && (redirect_src != NONE);

  always_comb begin
    raw_target = '0;
    case (redirect_src)
      QUAL2:   raw_target = TA_Warp_SIMT_IF;
      QUAL1:   raw_target = BrTarget_EX_IF;
      JUMP:    raw_target = JumpTarget_ID_IF;
      default: raw_target = '0;
    endcase
  end
  assign redirect_target = raw_target & ALIGN_MASK;

  // A response that misses, or that finds the slot still held, is rolled
  // back and re-fetched; both cases share one replay path.
  assign resp_reject = inflight_reg && !(bus.Hit_ICache_IF && slot_can_accept);
  // Redirects squash the response arriving in the redirect cycle.
  assign slot_load   = inflight_reg && bus.Hit_ICache_IF && slot_can_accept &&
                       !redirect_taken;

  assign req = run_now && !Exit_ID_IF && !Stall_SIMT_IF &&
               (redirect_src == NONE) && slot_can_accept && !resp_reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= req;
      case (state_reg)
        IDLE: begin
          if (Start_TM_IF) begin
            state_reg <= RUN;
            pc_reg    <= StartPC_TM_IF & ALIGN_MASK;
          end
        end
        RUN: begin
          if (Exit_ID_IF) begin
            state_reg <= DRAIN;
          end else if (redirect_taken) begin
            pc_reg <= redirect_target;
          end else if (req) begin
            req_pc_reg <= pc_reg;
            pc_reg     <= pc_reg + STEP;
          end else if (resp_reject) begin
            pc_reg <= req_pc_reg;
          end
        end
        DRAIN: begin
          if (!inflight_reg && (!slot_valid || bus.Ready_IB_IF))
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  fetch_out_slot #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_slot (
    .clk          (clk),
    .rst          (rst),
    .load         (slot_load),
    .load_instr   (bus.Instr_ICache_IF),
    .load_pcplus4 (req_pc_reg + STEP),
    .flush        (redirect_taken),
    .ready        (bus.Ready_IB_IF),
    .valid        (slot_valid),
    .instr        (bus.Instr_IF_IB),
    .pcplus4      (bus.PCplus4_IF_IB),
    .can_accept   (slot_can_accept)
  );

  assign bus.Req_IF_ICache  = req;
  assign bus.Addr_IF_ICache = pc_reg;
  assign bus.Valid_IF_IB    = slot_valid;
  assign Active_IF_TM       = (state_reg != IDLE);

`ifdef FETCH_PERF_CNT_EN
  logic [2:0] perf_event;
  logic       perf_clear;

  assign perf_clear    = (state_reg == IDLE) && Start_TM_IF;
  assign perf_event[0] = run_now && Stall_SIMT_IF;
  assign perf_event[1] = inflight_reg && !bus.Hit_ICache_IF;
  assign perf_event[2] = redirect_taken;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_reg <= '0;
      else if (perf_clear)
        cnt_reg <= '0;
      else if (perf_event[gi] && (cnt_reg != 16'hFFFF))
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign StallCycles_IF = g_perf[0].cnt_reg;
  assign MissCycles_IF  = g_perf[1].cnt_reg;
  assign Redirects_IF   = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_warp_fetch_pc.sv
// ----------------------------------------------------------------------------
// tb_warp_fetch_pc
// Directed scenarios for warp_fetch_pc with an I-cache responder and a
// scoreboard of expected IB deliveries (pc+4, instruction), popped on every
// Valid&Ready handshake.
// ----------------------------------------------------------------------------
module tb_warp_fetch_pc;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start, exit_id, stall, qual1, qual2, jump;
  logic [PC_W-1:0] start_pc, br_target, ta_target, jump_target;
  logic            active;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     stall_cycles, miss_cycles, redirects;
`endif

  warp_fetch_pc_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  warp_fetch_pc #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .Start_TM_IF            (start),
    .StartPC_TM_IF          (start_pc),
    .Exit_ID_IF             (exit_id),
    .Stall_SIMT_IF          (stall),
    .UpdatePC_Qual1_SIMT_IF (qual1),
    .BrTarget_EX_IF         (br_target),
    .UpdatePC_Qual2_SIMT_IF (qual2),
    .TA_Warp_SIMT_IF        (ta_target),
    .Jump_ID_IF             (jump),
    .JumpTarget_ID_IF       (jump_target),
    .bus                    (bus),
    .Active_IF_TM           (active)
`ifdef FETCH_PERF_CNT_EN
    ,
    .StallCycles_IF         (stall_cycles),
    .MissCycles_IF          (miss_cycles),
    .Redirects_IF           (redirects)
`endif
  );

  typedef struct packed {
    logic [PC_W-1:0]    pc4;
    logic [INSTR_W-1:0] instr;
  } ib_item_t;

  ib_item_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Values observed during the most recent cycle() call.
  logic               obs_req, obs_valid, obs_active;
  logic [PC_W-1:0]    obs_addr, obs_pc4;
  logic [INSTR_W-1:0] obs_instr;

  logic               miss_armed;
  logic [PC_W-1:0]    miss_addr;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic expect_ib(input logic [PC_W-1:0] addr);
    ib_item_t it;
    it.pc4   = addr + PC_W'(4);
    it.instr = mem_word(addr);
    sb_q.push_back(it);
  endtask

  task automatic clear_pulses();
    start   = 1'b0;
    exit_id = 1'b0;
    qual1   = 1'b0;
    qual2   = 1'b0;
    jump    = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs: sample outputs at the
  // falling edge, score any IB handshake, then after the rising edge drive
  // the I-cache response for the request just seen.
  task automatic cycle();
    ib_item_t it;
    logic     do_miss;
    @(negedge clk);
    obs_req    = bus.Req_IF_ICache;
    obs_addr   = bus.Addr_IF_ICache;
    obs_valid  = bus.Valid_IF_IB;
    obs_pc4    = bus.PCplus4_IF_IB;
    obs_instr  = bus.Instr_IF_IB;
    obs_active = active;
    if (bus.Valid_IF_IB && bus.Ready_IB_IF) begin
      check_eq("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        $display("IB accept pc4=0x%03h instr=0x%08h (exp pc4=0x%03h instr=0x%08h)",
                 bus.PCplus4_IF_IB, bus.Instr_IF_IB, it.pc4, it.instr);
        check_eq("ib_pc4", 64'(bus.PCplus4_IF_IB), 64'(it.pc4));
        check_eq("ib_instr", 64'(bus.Instr_IF_IB), 64'(it.instr));
      end
    end
    @(posedge clk);
    #1;
    do_miss = obs_req && miss_armed && (obs_addr == miss_addr);
    if (do_miss) miss_armed = 1'b0;
    bus.Hit_ICache_IF   = obs_req && !do_miss;
    bus.Instr_ICache_IF = obs_req ? mem_word(obs_addr) : '0;
    clear_pulses();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_req"},    64'(bus.Req_IF_ICache),  64'd0);
    check_eq({tag, "_addr"},   64'(bus.Addr_IF_ICache), 64'd0);
    check_eq({tag, "_valid"},  64'(bus.Valid_IF_IB),    64'd0);
    check_eq({tag, "_instr"},  64'(bus.Instr_IF_IB),    64'd0);
    check_eq({tag, "_pc4"},    64'(bus.PCplus4_IF_IB),  64'd0);
    check_eq({tag, "_active"}, 64'(active),             64'd0);
  endtask

  // Reset, confirm every expected delivery was seen, then launch at pc.
  // Returns after the Start cycle.
  task automatic restart(input logic [PC_W-1:0] pc);
    rst = 1'b1;
    clear_pulses();
    stall               = 1'b0;
    start_pc            = '0;
    br_target           = '0;
    ta_target           = '0;
    jump_target         = '0;
    bus.Hit_ICache_IF   = 1'b0;
    bus.Instr_ICache_IF = '0;
    bus.Ready_IB_IF     = 1'b1;
    miss_armed          = 1'b0;
    miss_addr           = '0;
    @(negedge clk);
    check_outputs_zero("reset");
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    start    = 1'b1;
    start_pc = pc;
    cycle();
    check_eq("start_req", 64'(obs_req), 64'd0);
  endtask

  initial begin
    // ---- 1: straight-line fetch ----
    restart(10'd0);
    expect_ib(10'd0); expect_ib(10'd4); expect_ib(10'd8);
    cycle();
    check_eq("s1_req0", 64'(obs_req), 64'd1);
    check_eq("s1_addr0", 64'(obs_addr), 64'd0);
    check_eq("s1_active", 64'(obs_active), 64'd1);
    cycle();
    check_eq("s1_addr4", 64'(obs_addr), 64'd4);
    check_eq("s1_req4", 64'(obs_req), 64'd1);
    check_eq("s1_valid_early", 64'(obs_valid), 64'd0);
    cycle();
    check_eq("s1_addr8", 64'(obs_addr), 64'd8);
    check_eq("s1_valid_rise", 64'(obs_valid), 64'd1);
    stall = 1'b1;
    cycle();
    check_eq("s1_stall_req", 64'(obs_req), 64'd0);
    cycle();

    // ---- 2: stall then Qual1 as stall falls ----
    restart(10'd0);
    expect_ib(10'd0); expect_ib(10'd12);
    cycle();
    check_eq("s2_addr0", 64'(obs_addr), 64'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("s2_stall_req", 64'(obs_req), 64'd0);
      check_eq("s2_pc_held", 64'(obs_addr), 64'd4);
    end
    stall = 1'b0; qual1 = 1'b1; br_target = 10'd14;
    cycle();
    check_eq("s2_redir_req", 64'(obs_req), 64'd0);
    cycle();
    check_eq("s2_tgt_req", 64'(obs_req), 64'd1);
    check_eq("s2_tgt_addr", 64'(obs_addr), 64'd12);
    stall = 1'b1;
    cycle();
    cycle();

    // ---- 3: Qual2 beats Qual1/Jump, squash; jump in stall; PC wrap ----
    restart(10'd0);
    expect_ib(10'd16); expect_ib(10'h3FC); expect_ib(10'd0);
    cycle();
    check_eq("s3_addr0", 64'(obs_addr), 64'd0);
    qual2 = 1'b1; ta_target = 10'd16; qual1 = 1'b1; br_target = 10'd24;
    jump = 1'b1; jump_target = 10'd40;
    cycle();
    check_eq("s3_redir_req", 64'(obs_req), 64'd0);
    cycle();
    check_eq("s3_squash_valid", 64'(obs_valid), 64'd0);
    check_eq("s3_q2_req", 64'(obs_req), 64'd1);
    check_eq("s3_q2_addr", 64'(obs_addr), 64'd16);
    stall = 1'b1;
    cycle();
    cycle();
    jump = 1'b1; jump_target = 10'h3FE;
    cycle();
    check_eq("s3_jump_stall_req", 64'(obs_req), 64'd0);
    stall = 1'b0;
    cycle();
    check_eq("s3_jump_addr", 64'(obs_addr), 64'h3FC);
    check_eq("s3_jump_req", 64'(obs_req), 64'd1);
    cycle();
    check_eq("s3_wrap_addr", 64'(obs_addr), 64'd0);
    stall = 1'b1;
    cycle();
    cycle();

    // ---- 4: miss on 8, replay ----
    restart(10'd0);
    miss_armed = 1'b1; miss_addr = 10'd8;
    expect_ib(10'd0); expect_ib(10'd4); expect_ib(10'd8); expect_ib(10'd12);
    cycle();
    cycle();
    cycle();
    check_eq("s4_addr8", 64'(obs_addr), 64'd8);
    cycle();
    check_eq("s4_miss_req", 64'(obs_req), 64'd0);
    cycle();
    check_eq("s4_replay_req", 64'(obs_req), 64'd1);
    check_eq("s4_replay_addr", 64'(obs_addr), 64'd8);
    check_eq("s4_replay_valid", 64'(obs_valid), 64'd0);
    cycle();
    check_eq("s4_next_addr", 64'(obs_addr), 64'd12);
    stall = 1'b1;
    cycle();
    cycle();

    // ---- 5: IB backpressure, then reset mid-RUN ----
    restart(10'd0);
    expect_ib(10'd0); expect_ib(10'd4);
    cycle();
    cycle();
    bus.Ready_IB_IF = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("s5_full_req", 64'(obs_req), 64'd0);
      check_eq("s5_hold_valid", 64'(obs_valid), 64'd1);
      check_eq("s5_hold_pc4", 64'(obs_pc4), 64'd4);
      check_eq("s5_hold_instr", 64'(obs_instr), 64'(mem_word(10'd0)));
    end
    bus.Ready_IB_IF = 1'b1;
    cycle();
    check_eq("s5_resume_req", 64'(obs_req), 64'd1);
    check_eq("s5_resume_addr", 64'(obs_addr), 64'd4);
    cycle();
    cycle();
    check_eq("s5_prerst_req", 64'(obs_req), 64'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrun_rst");

    // ---- 6: Exit with a request in flight, jump discarded ----
    restart(10'd0);
    expect_ib(10'd0);
    cycle();
    check_eq("s6_addr0", 64'(obs_addr), 64'd0);
    exit_id = 1'b1; bus.Ready_IB_IF = 1'b0; jump = 1'b1; jump_target = 10'h80;
    cycle();
    check_eq("s6_exit_req", 64'(obs_req), 64'd0);
    cycle();
    check_eq("s6_drain_valid", 64'(obs_valid), 64'd1);
    check_eq("s6_drain_active", 64'(obs_active), 64'd1);
    check_eq("s6_drain_req", 64'(obs_req), 64'd0);
    bus.Ready_IB_IF = 1'b1;
    cycle();
    check_eq("s6_accept_active", 64'(obs_active), 64'd1);
    cycle();
    check_eq("s6_idle_active", 64'(obs_active), 64'd0);
    check_eq("s6_idle_valid", 64'(obs_valid), 64'd0);
    check_eq("s6_idle_req", 64'(obs_req), 64'd0);
    check_eq("s6_jump_dropped", 64'(obs_addr), 64'd4);

    check_eq("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
